// File: rtl/peripheral_bin2bcd_n.sv
// peripheral_bin2bcd_n: memory-mapped binary-to-BCD converter on the J1 I/O bus.
// Iterative double-dabble, one input bit per clock, with done/busy/ovf status.
// Optional macro BIN2BCD_SIGNED_EN: CTRL bit1 selects two's-complement input,
// the magnitude is converted and the sign is reported in BCD_HI[15]/STATUS[3].
module peripheral_bin2bcd_n #(
    parameter int DATA_W     = 16,
    parameter int DIGITS     = 5,
    parameter int SAT_ON_OVF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out
);

    // Decimal digits needed for DATA_W bits: ceil(DATA_W*log10(2)+1), capped at 5.
    localparam int ACC_RAW = (DATA_W * 30103) / 100000 + 2;
    localparam int ACC_D   = (ACC_RAW > 5) ? 5 : ACC_RAW;
    localparam int ACC_W   = 4 * ACC_D;
    localparam int RES_W   = 4 * DIGITS;
    localparam int CNT_W   = 5;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_DATA   = 4'h2;
    localparam logic [3:0] A_BCD_LO = 4'h4;
    localparam logic [3:0] A_BCD_HI = 4'h6;
    localparam logic [3:0] A_STATUS = 4'h8;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        d_out_q, d_out_d;
    logic               sign_q;

`ifdef BIN2BCD_SIGNED_EN
    logic               sign_d;
    logic               mode_q, mode_d;
    logic               psign_q, psign_d;   // sign captured at start, published at FINISH
`else
    assign sign_q = 1'b0;
`endif

    logic               wr_en, rd_en, start;
    logic               neg;
    logic [DATA_W-1:0]  mag;
    logic [ACC_W-1:0]   acc_adj;
    logic [19:0]        acc_ext, res_ext;
    logic [RES_W-1:0]   res_sel;
    logic               ovf_now;

    assign acc_ext = 20'(acc_q);
    assign res_ext = 20'(result_q);
    assign d_out   = d_out_q;

    // Bus decode, read mux, digit adjust and conversion FSM next-state logic
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        d_out_d  = 16'h0000;
`ifdef BIN2BCD_SIGNED_EN
        sign_d   = sign_q;
        mode_d   = mode_q;
        psign_d  = psign_q;
`endif
        wr_en = cs & wr;
        rd_en = cs & rd;

        // Reads see the registers as they were before this edge's write.
        if (rd_en) begin
            case (addr)
                A_BCD_LO: d_out_d = res_ext[15:0];
                A_BCD_HI: d_out_d = {sign_q, 11'b0, res_ext[19:16]};
                A_STATUS: d_out_d = {12'b0, sign_q, ovf_q, busy_q, done_q};
                default:  d_out_d = 16'h0000;
            endcase
        end

        if (wr_en && addr == A_DATA)
            data_d = d_in[DATA_W-1:0];

        // The mode bit of the start write itself governs that conversion.
`ifdef BIN2BCD_SIGNED_EN
        if (wr_en && addr == A_CTRL)
            mode_d = d_in[1];
        neg = d_in[1] & data_q[DATA_W-1];
`else
        neg = 1'b0;
`endif
        mag   = neg ? (~data_q + 1'b1) : data_q;
        start = wr_en && (addr == A_CTRL) && d_in[0];

        // Add 3 to every nibble >= 5 ahead of the shift
        acc_adj = acc_q;
        for (int i = 0; i < ACC_D; i++)
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;

        // Overflow: a nonzero digit beyond what the result can hold
        ovf_now = 1'b0;
        for (int i = 0; i < 5; i++)
            if (i >= DIGITS && acc_ext[4*i +: 4] != 4'h0)
                ovf_now = 1'b1;

        res_sel = '0;
        for (int i = 0; i < DIGITS; i++)
            res_sel[4*i +: 4] = (ovf_now && SAT_ON_OVF != 0) ? 4'h9 : acc_ext[4*i +: 4];

        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = mag;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = SHIFT;
`ifdef BIN2BCD_SIGNED_EN
                    psign_d = neg;
`endif
                end
            end
            SHIFT: begin
                acc_d   = {acc_adj[ACC_W-2:0], shreg_q[DATA_W-1]};
                shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = FINISH;
            end
            FINISH: begin
                result_d = res_sel;
                ovf_d    = ovf_now;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
`ifdef BIN2BCD_SIGNED_EN
                sign_d   = psign_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // All state, with asynchronous active-low clear that also aborts a conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            d_out_q  <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q   <= 1'b0;
            mode_q   <= 1'b0;
            psign_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            d_out_q  <= d_out_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q   <= sign_d;
            mode_q   <= mode_d;
            psign_q  <= psign_d;
`endif
        end
    end

endmodule

// File: doc/peripheral_bin2bcd_n.md
Name: peripheral_bin2bcd_n

Overview:
- Parametrised memory-mapped binary-to-BCD converter peripheral on the J1 I/O bus.
- Successor to the fixed 14-bit / 4-digit converter: configurable input width and digit count.
- Iterative double-dabble engine, one bit per clock, with busy/done/overflow status.
- Selected by the I/O address decoder via cs. Firmware polls STATUS, then reads packed BCD words.

Parameters:
- DATA_W, 16: binary input width, legal 4..16.
- DIGITS, 5: BCD output digits, legal 1..5.
- SAT_ON_OVF, 1: 1 = overflowed result reads as all nines; 0 = truncated low digits.

Ports:
- clk  in  1  system clock; all registers on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- d_in  in  16  write data from J1.
- cs  in  1  peripheral select.
- addr  in  4  4 LSB of j1_io_addr.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_out  out  16  registered read data.

Behaviour:
- Register map, 16-bit words; writes require cs&wr, reads require cs&rd; unmapped addresses write nothing and read 0.
  - 0x0 CTRL (W): bit0 start (self-clearing pulse); bit1 signed mode (see feature).
  - 0x2 DATA (W): d_in[DATA_W-1:0] written to the data register.
  - 0x4 BCD_LO (R): digits 3..0 packed, digit0 in [3:0].
  - 0x6 BCD_HI (R): digit4 in [3:0]; bit15 = sign; other bits 0.
  - 0x8 STATUS (R): bit0 done, bit1 busy, bit2 ovf, bit3 sign; others 0.
  - Digits at index >= DIGITS read 0.
- Read timing: d_out is updated on the clk edge where the read is sampled, so data is valid the following cycle. With no read selected, d_out = 0.
- Reset (rst low, asynchronous) clears: d_out, data, result, done, busy, ovf, sign, the FSM (to IDLE) and the iteration counter. Reset mid-conversion aborts it, and no done is produced.
- FSM states: IDLE, SHIFT, FINISH.
  - IDLE + start write at edge E0: the data register is copied into the shift register, the BCD accumulator is cleared, count = DATA_W, busy = 1, done = 0, ovf = 0. Next state is SHIFT.
  - SHIFT: each edge adds 3 to every accumulator nibble >= 5, then shifts {acc, shreg} left by 1 and decrements count. After DATA_W edges, go to FINISH.
  - FINISH: one edge loads the result registers, sets done = 1 and busy = 0, then returns to IDLE.
- Latency: done and the result are visible DATA_W+1 edges after E0; with DATA_W=16 that is edge E17.
- Accumulator width: 4*ceil(DATA_W*log10(2)+1) digits, internally capped at 5 digits.
  - ovf = 1 when any accumulated digit at index >= DIGITS is nonzero.
  - On ovf with SAT_ON_OVF=1, result = all nines. With SAT_ON_OVF=0, the low DIGITS digits are kept.
- done is sticky until the next accepted start.
- Result registers hold their last value until FINISH of the next conversion.
- Start while busy is ignored: no restart, no state change.
- DATA write while busy updates the data register only. The conversion in flight is unaffected.
- A CTRL write with bit0 = 0 has no effect except updating the mode bit.
- Simultaneous wr and rd with cs: both are performed. The read returns the pre-write value.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined: CTRL bit1 is stored as the mode. With mode = 1, start treats data[DATA_W-1] as a two's-complement sign:
  - the shift register loads the magnitude;
  - sign = msb is latched at FINISH;
  - the most-negative value converts its magnitude 2^(DATA_W-1) correctly.
- Undefined: CTRL bit1 is ignored, no mode register exists, and sign, BCD_HI[15] and STATUS[3] read 0.

Test Plan:
- Defaults. Write 0x2 = 0x04D2, then 0x0 = 0x0001 → busy = 1 for 17 cycles, then STATUS = 0x0001, BCD_LO = 0x1234, BCD_HI = 0x0000.
- DATA = 0xFFFF, start → BCD_LO = 0x5535, BCD_HI = 0x0006, ovf = 0.
- Start, then rewrite DATA = 0x0009 and pulse start again while busy → first result unchanged, the second start is ignored, and a later start converts 9 → BCD_LO = 0x0009.
- Instance DIGITS=4, SAT_ON_OVF=1, DATA = 10000 → STATUS = 0x0005, BCD_LO = 0x9999. With SAT_ON_OVF=0 → BCD_LO = 0x0000, ovf = 1.
- Assert rst low for 1 cycle at iteration 8 → busy = 0 and done = 0 immediately, d_out = 0. A subsequent conversion of 42 gives 0x0042.
- With BIN2BCD_SIGNED_EN, CTRL = 0x0003, DATA = 0xFB2E → BCD_LO = 0x1234, BCD_HI = 0x8000, STATUS = 0x0009.
- With BIN2BCD_SIGNED_EN, DATA = 0x8000 signed → BCD_LO = 0x2768, BCD_HI = 0x8003.
